// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared FSM encoding, width defaults and reset level for the fetch stage
package if_stage_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic RST_ENABLE = 1'b0;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction memory request/response bus
interface if_stage_if import if_stage_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic inst_addr_ok;
  logic inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  modport master(output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave(input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry hold buffer for a fetched payload that ID cannot take yet
module if_skid_buf import if_stage_pkg::*; #(
  parameter int W = 65
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  logic [W-1:0] din,
  output logic full,
  output logic [W-1:0] dout
);
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ENABLE) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) full <= 1'b0;
    else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) full <= 1'b0;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding request, flush cancel and IF/ID output register
module if_stage import if_stage_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic ce_i,
  output logic fs_stall_req,
  if_stage_if.master mem,
  input  logic id_allowin,
  input  logic flush,
  output logic id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic id_adel
);
  localparam int PW = ADDR_W + DATA_W + 1;
  state_t state, state_nx;
  logic cancel, cancel_nx, hold_full, accept, misalign, deliver, to_out, pop;
  logic [ADDR_W-1:0] pc_q, pc_nx;
  logic [PW-1:0] payload, hold_q;
  assign misalign = pc_i[1:0] != 2'b00;
  assign fs_stall_req = !(state == S_IDLE && !hold_full);
  assign accept = !fs_stall_req && ce_i && !flush;
  assign mem.inst_req = state == S_REQ;
  assign mem.inst_addr = pc_q;
  assign to_out = !id_valid || id_allowin;
  assign pop = id_allowin && hold_full && !deliver;
  // A flush seen while the request is still pending cannot withdraw it; it is remembered in cancel.
  always_comb begin
    state_nx = state;
    cancel_nx = 1'b0;
    pc_nx = pc_q;
    deliver = 1'b0;
    payload = {pc_q, mem.inst_rdata, 1'b0};
    case (state)
      S_IDLE: if (accept) begin
        payload = {pc_i, {DATA_W{1'b0}}, 1'b1};
        deliver = misalign;
        pc_nx = misalign ? pc_q : pc_i;
        state_nx = misalign ? S_IDLE : S_REQ;
      end
      S_REQ: begin
        cancel_nx = (cancel || flush) && !mem.inst_addr_ok;
        if (mem.inst_addr_ok) state_nx = (cancel || flush) ? S_DROP : S_WAIT;
      end
      S_WAIT: if (flush) state_nx = mem.inst_data_ok ? S_IDLE : S_DROP;
      else if (mem.inst_data_ok) begin
        deliver = 1'b1;
        state_nx = S_IDLE;
      end
      S_DROP: if (mem.inst_data_ok) state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ENABLE) begin
      state <= S_IDLE;
      cancel <= 1'b0;
      pc_q <= '0;
    end else begin
      state <= state_nx;
      cancel <= cancel_nx;
      pc_q <= pc_nx;
    end
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ENABLE) begin
      id_valid <= 1'b0;
      {id_pc, id_inst, id_adel} <= '0;
    end else if (flush) id_valid <= 1'b0;
    else if (deliver && to_out) begin
      id_valid <= 1'b1;
      {id_pc, id_inst, id_adel} <= payload;
    end else if (pop) begin
      id_valid <= 1'b1;
      {id_pc, id_inst, id_adel} <= hold_q;
    end else if (id_allowin) id_valid <= 1'b0;
  if_skid_buf #(.W(PW)) u_hold (
    .clk(clk),
    .rst(rst),
    .push(deliver && !to_out),
    .pop(pop),
    .clear(flush),
    .din(payload),
    .full(hold_full),
    .dout(hold_q)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table, flush/reset sequences and randomized run against a queue model
module tb_if_stage;
  typedef struct {
    logic [31:0] pc;
    logic [4:0] in;
    logic [31:0] rdata;
    logic [2:0] ex;
    logic [31:0] ea, epc, einst;
    logic eadel;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc_i;
  logic ce_i, fs_stall_req, id_allowin, flush, id_valid, id_adel;
  logic [31:0] id_pc, id_inst;
  int tests = 0;
  int fails = 0;
  vec_t tbl[16];
  int ph;
  logic killed;
  logic [31:0] mpc;
  logic [64:0] q[$];
  if_stage_if #(.ADDR_W(32), .DATA_W(32)) bus();
  if_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .pc_i(pc_i),
    .ce_i(ce_i),
    .fs_stall_req(fs_stall_req),
    .mem(bus),
    .id_allowin(id_allowin),
    .flush(flush),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_adel(id_adel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] p, input logic [4:0] in, input logic [31:0] rd);
    pc_i = p;
    {ce_i, bus.inst_addr_ok, bus.inst_data_ok, id_allowin, flush} = in;
    bus.inst_rdata = rd;
    #1;
  endtask
  // in = {ce, addr_ok, data_ok, allowin, flush}; ex = {stall, req, valid} seen in that cycle
  task automatic run(input vec_t v, input string tag);
    drive(v.pc, v.in, v.rdata);
    chk({tag, " stall"}, fs_stall_req, v.ex[2]);
    chk({tag, " req"}, bus.inst_req, v.ex[1]);
    if (v.ex[1]) chk({tag, " addr"}, bus.inst_addr, v.ea);
    chk({tag, " valid"}, id_valid, v.ex[0]);
    if (v.ex[0]) chk({tag, " payload"}, {id_pc, id_inst, id_adel}, {v.epc, v.einst, v.eadel});
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] p, rd;
    logic c, a, d, al, f, es;
    drive(0, 5'b00010, 0);
    tbl[0]  = '{32'hbfc00000, 5'b10010, 0, 3'b000, 0, 0, 0, 1'b0};
    tbl[1]  = '{0, 5'b01010, 0, 3'b110, 32'hbfc00000, 0, 0, 1'b0};
    tbl[2]  = '{0, 5'b00110, 32'h24020001, 3'b100, 0, 0, 0, 1'b0};
    tbl[3]  = '{0, 5'b00010, 0, 3'b001, 0, 32'hbfc00000, 32'h24020001, 1'b0};
    tbl[4]  = '{32'hbfc00002, 5'b10010, 0, 3'b000, 0, 0, 0, 1'b0};
    tbl[5]  = '{0, 5'b00010, 0, 3'b001, 0, 32'hbfc00002, 0, 1'b1};
    tbl[6]  = '{32'h1000, 5'b10010, 0, 3'b000, 0, 0, 0, 1'b0};
    tbl[7]  = '{0, 5'b01010, 0, 3'b110, 32'h1000, 0, 0, 1'b0};
    tbl[8]  = '{0, 5'b00110, 32'h11111111, 3'b100, 0, 0, 0, 1'b0};
    tbl[9]  = '{32'h1004, 5'b10000, 0, 3'b001, 0, 32'h1000, 32'h11111111, 1'b0};
    tbl[10] = '{0, 5'b01000, 0, 3'b111, 32'h1004, 32'h1000, 32'h11111111, 1'b0};
    tbl[11] = '{0, 5'b00100, 32'h22222222, 3'b101, 0, 32'h1000, 32'h11111111, 1'b0};
    tbl[12] = '{32'h1008, 5'b10000, 0, 3'b101, 0, 32'h1000, 32'h11111111, 1'b0};
    tbl[13] = '{0, 5'b00010, 0, 3'b101, 0, 32'h1000, 32'h11111111, 1'b0};
    tbl[14] = '{0, 5'b00010, 0, 3'b001, 0, 32'h1004, 32'h22222222, 1'b0};
    tbl[15] = '{0, 5'b00010, 0, 3'b000, 0, 0, 0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset stall", fs_stall_req, 0);
    chk("reset req", bus.inst_req, 0);
    chk("reset addr", bus.inst_addr, 0);
    chk("reset valid", id_valid, 0);
    chk("reset payload", {id_pc, id_inst, id_adel}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset stall", fs_stall_req, 0);
    for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("row%0d", i));
    // flush while the request waits for addr_ok: request held, response dropped
    run('{32'h2000, 5'b10010, 0, 3'b000, 0, 0, 0, 1'b0}, "freq0");
    run('{0, 5'b00011, 0, 3'b110, 32'h2000, 0, 0, 1'b0}, "freq1");
    run('{0, 5'b00010, 0, 3'b110, 32'h2000, 0, 0, 1'b0}, "freq2");
    run('{0, 5'b01010, 0, 3'b110, 32'h2000, 0, 0, 1'b0}, "freq3");
    run('{32'h3000, 5'b10010, 0, 3'b100, 0, 0, 0, 1'b0}, "freq4");
    run('{0, 5'b00110, 32'hdeadbeef, 3'b100, 0, 0, 0, 1'b0}, "freq5");
    run('{0, 5'b00010, 0, 3'b000, 0, 0, 0, 1'b0}, "freq6");
    run('{0, 5'b00010, 0, 3'b000, 0, 0, 0, 1'b0}, "freq7");
    // flush coincident with data_ok in WAIT, then an immediate new fetch
    run('{32'h4000, 5'b10010, 0, 3'b000, 0, 0, 0, 1'b0}, "fwait0");
    run('{0, 5'b01010, 0, 3'b110, 32'h4000, 0, 0, 1'b0}, "fwait1");
    run('{0, 5'b00111, 32'hcafef00d, 3'b100, 0, 0, 0, 1'b0}, "fwait2");
    run('{32'h4004, 5'b10010, 0, 3'b000, 0, 0, 0, 1'b0}, "fwait3");
    run('{0, 5'b01010, 0, 3'b110, 32'h4004, 0, 0, 1'b0}, "fwait4");
    run('{0, 5'b00110, 32'h12345678, 3'b100, 0, 0, 0, 1'b0}, "fwait5");
    run('{0, 5'b00010, 0, 3'b001, 0, 32'h4004, 32'h12345678, 1'b0}, "fwait6");
    run('{0, 5'b00010, 0, 3'b000, 0, 0, 0, 1'b0}, "fwait7");
    // asynchronous reset in WAIT with a held payload, then a stale data_ok
    run('{32'hbfc00002, 5'b10000, 0, 3'b000, 0, 0, 0, 1'b0}, "rst0");
    run('{32'h5000, 5'b10000, 0, 3'b001, 0, 32'hbfc00002, 0, 1'b1}, "rst1");
    run('{0, 5'b01000, 0, 3'b111, 32'h5000, 32'hbfc00002, 0, 1'b1}, "rst2");
    drive(0, 5'b00000, 0);
    rst = 1'b0;
    #1;
    chk("async rst req", bus.inst_req, 0);
    chk("async rst addr", bus.inst_addr, 0);
    chk("async rst valid", id_valid, 0);
    chk("async rst payload", {id_pc, id_inst, id_adel}, 0);
    chk("async rst stall", fs_stall_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run('{0, 5'b00110, 32'hbadbad00, 3'b000, 0, 0, 0, 1'b0}, "stale0");
    run('{0, 5'b00010, 0, 3'b000, 0, 0, 0, 1'b0}, "stale1");
    run('{0, 5'b00010, 0, 3'b000, 0, 0, 0, 1'b0}, "stale2");
    // randomized traffic against a transaction-level model: q holds what ID will see, in order
    ph = 0;
    killed = 1'b0;
    mpc = 0;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      p = $urandom;
      if ($urandom_range(7) != 0) p[1:0] = 2'b00;
      c = $urandom_range(3) != 0;
      a = (ph == 1) && ($urandom_range(2) != 0);
      d = (ph == 2) && ($urandom_range(2) != 0);
      rd = $urandom;
      al = $urandom_range(3) != 0;
      f = $urandom_range(15) == 0;
      drive(p, {c, a, d, al, f}, rd);
      es = (ph != 0) || (q.size() == 2);
      chk("rnd stall", fs_stall_req, es);
      chk("rnd req", bus.inst_req, ph == 1);
      if (ph == 1) chk("rnd addr", bus.inst_addr, mpc);
      chk("rnd valid", id_valid, q.size() != 0);
      if (q.size() != 0) chk("rnd payload", {id_pc, id_inst, id_adel}, q[0]);
      if (f) q.delete();
      else if (al && q.size() != 0) void'(q.pop_front());
      if (ph == 0) begin
        if (!es && c && !f) begin
          if (p[1:0] != 2'b00) q.push_back({p, 32'h0, 1'b1});
          else begin
            ph = 1;
            mpc = p;
            killed = 1'b0;
          end
        end
      end else if (ph == 1) begin
        killed = killed | f;
        if (a) ph = 2;
      end else if (d) begin
        if (!killed && !f) q.push_back({mpc, rd, 1'b0});
        ph = 0;
      end else killed = killed | f;
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
